// File: rtl/fp32_add_sub_unit.sv
// IEEE-754 binary32 adder/subtractor, multi-cycle, stb/ack handshakes on A, B and Z.
// Optional macro ADDSUB_OP_EN adds the op_sub port (1 = A-B); otherwise the unit adds only.
module fp32_add_sub_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
`ifdef ADDSUB_OP_EN
    input  logic        op_sub,
`endif
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [3:0] {
        GET_A     = 4'd0,
        GET_B     = 4'd1,
        UNPACK    = 4'd2,
        SPECIAL   = 4'd3,
        ALIGN     = 4'd4,
        ADD       = 4'd5,
        NORMALISE = 4'd6,
        ROUND     = 4'd7,
        PACK      = 4'd8,
        PUT_Z     = 4'd9
    } state_t;

    localparam logic signed [9:0] EXP_MIN  = -10'sd126;
    localparam logic signed [9:0] EXP_MAX  = 10'sd127;
    localparam logic signed [9:0] EXP_BIAS = 10'sd127;
    localparam logic [31:0]       QNAN     = 32'h7FC0_0000;

    state_t            state_r;
    state_t            next_state_s;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic [31:0]       z_r;
    logic [31:0]       output_z_r;
    logic              input_a_ack_r;
    logic              input_b_ack_r;
    logic              output_z_stb_r;
    logic              a_s_r;
    logic              b_s_r;
    logic              z_s_r;
    logic signed [9:0] a_e_r;
    logic signed [9:0] b_e_r;
    logic signed [9:0] z_e_r;
    logic [26:0]       a_m_r;
    logic [26:0]       b_m_r;
    logic [27:0]       z_m_r;

    logic              a_acc_s;
    logic              b_acc_s;
    logic              z_done_s;
    logic              sub_s;
    logic              a_nan_s;
    logic              b_nan_s;
    logic              a_inf_s;
    logic              b_inf_s;
    logic              a_zero_s;
    logic              b_zero_s;
    logic              special_s;
    logic [31:0]       special_z_s;
    logic [27:0]       sum_s;
    logic              sum_sign_s;
    logic              sum_zero_s;
    logic              norm_done_s;
    logic              round_up_s;
    logic [24:0]       mant_rnd_s;
    logic [7:0]        exp_field_s;
    logic [31:0]       pack_z_s;

    assign a_acc_s  = input_a_stb & input_a_ack_r;
    assign b_acc_s  = input_b_stb & input_b_ack_r;
    assign z_done_s = output_z_stb_r & output_z_ack;

    assign input_a_ack  = input_a_ack_r;
    assign input_b_ack  = input_b_ack_r;
    assign output_z     = output_z_r;
    assign output_z_stb = output_z_stb_r;

`ifdef ADDSUB_OP_EN
    logic op_sub_r;

    // Captures the operation select together with operand B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sub_r <= 1'b0;
        end else if (b_acc_s) begin
            op_sub_r <= op_sub;
        end else begin
            op_sub_r <= op_sub_r;
        end
    end

    assign sub_s = op_sub_r;
`else
    assign sub_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= GET_A;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            GET_A:     if (a_acc_s) next_state_s = GET_B; else next_state_s = GET_A;
            GET_B:     if (b_acc_s) next_state_s = UNPACK; else next_state_s = GET_B;
            UNPACK:    next_state_s = SPECIAL;
            SPECIAL:   if (special_s) next_state_s = PUT_Z; else next_state_s = ALIGN;
            ALIGN:     if (a_e_r == b_e_r) next_state_s = ADD; else next_state_s = ALIGN;
            ADD:       if (sum_zero_s) next_state_s = PUT_Z; else next_state_s = NORMALISE;
            NORMALISE: if (norm_done_s) next_state_s = ROUND; else next_state_s = NORMALISE;
            ROUND:     next_state_s = PACK;
            PACK:      next_state_s = PUT_Z;
            PUT_Z:     if (z_done_s) next_state_s = GET_A; else next_state_s = PUT_Z;
            default:   next_state_s = GET_A;
        endcase
    end

    // Special-operand classification and result, in priority order.
    always_comb begin
        a_nan_s     = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan_s     = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
        a_inf_s     = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf_s     = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
        a_zero_s    = (a_r[30:0] == 31'd0);
        b_zero_s    = (b_r[30:0] == 31'd0);
        special_s   = 1'b1;
        special_z_s = 32'd0;
        if (a_nan_s || b_nan_s) begin
            special_z_s = QNAN;
        end else if (a_inf_s && b_inf_s && (a_s_r != b_s_r)) begin
            special_z_s = QNAN;
        end else if (a_inf_s) begin
            special_z_s = {a_s_r, 8'hFF, 23'd0};
        end else if (b_inf_s) begin
            special_z_s = {b_s_r, 8'hFF, 23'd0};
        end else if (a_zero_s && b_zero_s) begin
            special_z_s = {a_s_r & b_s_r, 31'd0};
        end else if (a_zero_s) begin
            special_z_s = {b_s_r, b_r[30:0]};
        end else if (b_zero_s) begin
            special_z_s = {a_s_r, a_r[30:0]};
        end else begin
            special_s = 1'b0;
        end
    end

    // Signed-magnitude add of the aligned working mantissas.
    always_comb begin
        sum_s      = 28'd0;
        sum_sign_s = 1'b0;
        if (a_s_r == b_s_r) begin
            sum_s      = {1'b0, a_m_r} + {1'b0, b_m_r};
            sum_sign_s = a_s_r;
        end else if (a_m_r >= b_m_r) begin
            sum_s      = {1'b0, a_m_r} - {1'b0, b_m_r};
            sum_sign_s = a_s_r;
        end else begin
            sum_s      = {1'b0, b_m_r} - {1'b0, a_m_r};
            sum_sign_s = b_s_r;
        end
    end

    assign sum_zero_s  = (sum_s == 28'd0);
    assign norm_done_s = !z_m_r[27] && (z_m_r[26] || (z_e_r <= EXP_MIN));
    // Round to nearest, ties to even: bit 3 is the mantissa LSB.
    assign round_up_s  = z_m_r[2] & (z_m_r[1] | z_m_r[0] | z_m_r[3]);
    assign mant_rnd_s  = {1'b0, z_m_r[26:3]} + {24'd0, round_up_s};
    assign exp_field_s = z_e_r[7:0] + EXP_BIAS[7:0];

    // Final packing into binary32, including overflow and subnormal encodings.
    always_comb begin
        pack_z_s = {z_s_r, exp_field_s, z_m_r[25:3]};
        if (z_e_r > EXP_MAX) begin
            pack_z_s = {z_s_r, 8'hFF, 23'd0};
        end else if ((z_e_r == EXP_MIN) && !z_m_r[26]) begin
            pack_z_s = {z_s_r, 8'd0, z_m_r[25:3]};
        end else begin
            pack_z_s = {z_s_r, exp_field_s, z_m_r[25:3]};
        end
    end

    // Datapath registers, advanced according to the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            z_r   <= 32'd0;
            a_s_r <= 1'b0;
            b_s_r <= 1'b0;
            z_s_r <= 1'b0;
            a_e_r <= 10'sd0;
            b_e_r <= 10'sd0;
            z_e_r <= 10'sd0;
            a_m_r <= 27'd0;
            b_m_r <= 27'd0;
            z_m_r <= 28'd0;
        end else begin
            case (state_r)
                GET_A: begin
                    if (a_acc_s) a_r <= input_a;
                end
                GET_B: begin
                    if (b_acc_s) b_r <= input_b;
                end
                UNPACK: begin
                    a_s_r <= a_r[31];
                    b_s_r <= b_r[31] ^ sub_s;
                    a_m_r <= {(a_r[30:23] != 8'd0), a_r[22:0], 3'b000};
                    b_m_r <= {(b_r[30:23] != 8'd0), b_r[22:0], 3'b000};
                    a_e_r <= (a_r[30:23] == 8'd0) ? EXP_MIN : ($signed({2'b00, a_r[30:23]}) - EXP_BIAS);
                    b_e_r <= (b_r[30:23] == 8'd0) ? EXP_MIN : ($signed({2'b00, b_r[30:23]}) - EXP_BIAS);
                end
                SPECIAL: begin
                    if (special_s) z_r <= special_z_s;
                end
                ALIGN: begin
                    // Once only sticky remains, further shifting changes nothing: jump the exponent.
                    if (a_e_r > b_e_r) begin
                        if (b_m_r[26:1] == 26'd0) begin
                            b_e_r <= a_e_r;
                        end else begin
                            b_m_r <= {1'b0, b_m_r[26:2], b_m_r[1] | b_m_r[0]};
                            b_e_r <= b_e_r + 10'sd1;
                        end
                    end else if (b_e_r > a_e_r) begin
                        if (a_m_r[26:1] == 26'd0) begin
                            a_e_r <= b_e_r;
                        end else begin
                            a_m_r <= {1'b0, a_m_r[26:2], a_m_r[1] | a_m_r[0]};
                            a_e_r <= a_e_r + 10'sd1;
                        end
                    end
                end
                ADD: begin
                    z_m_r <= sum_s;
                    z_s_r <= sum_sign_s;
                    z_e_r <= a_e_r;
                    if (sum_zero_s) z_r <= 32'd0;
                end
                NORMALISE: begin
                    if (z_m_r[27]) begin
                        z_m_r <= {1'b0, z_m_r[27:2], z_m_r[1] | z_m_r[0]};
                        z_e_r <= z_e_r + 10'sd1;
                    end else if (!z_m_r[26] && (z_e_r > EXP_MIN)) begin
                        z_m_r <= {1'b0, z_m_r[25:0], z_m_r[0]};
                        z_e_r <= z_e_r - 10'sd1;
                    end
                end
                ROUND: begin
                    if (mant_rnd_s[24]) begin
                        z_m_r <= {1'b0, mant_rnd_s[24:1], 3'b000};
                        z_e_r <= z_e_r + 10'sd1;
                    end else begin
                        z_m_r <= {1'b0, mant_rnd_s[23:0], 3'b000};
                    end
                end
                PACK: begin
                    z_r <= pack_z_s;
                end
                PUT_Z: begin
                    z_r <= z_r;
                end
                default: begin
                    z_r <= z_r;
                end
            endcase
        end
    end

    // Registered handshake outputs and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_a_ack_r  <= 1'b0;
            input_b_ack_r  <= 1'b0;
            output_z_stb_r <= 1'b0;
            output_z_r     <= 32'd0;
        end else begin
            input_a_ack_r  <= (state_r == GET_A) && !a_acc_s;
            input_b_ack_r  <= (state_r == GET_B) && !b_acc_s;
            output_z_stb_r <= (state_r == PUT_Z) && !z_done_s;
            if (state_r == PUT_Z) begin
                output_z_r <= z_r;
            end else begin
                output_z_r <= output_z_r;
            end
        end
    end

endmodule

// File: tb/tb_fp32_add_sub_unit.sv
// Directed bench for fp32_add_sub_unit: reset, arithmetic vectors, backpressure, handshake and mid-op reset.
module tb_fp32_add_sub_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic        op_sub;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int checks   = 0;
    int failures = 0;

    fp32_add_sub_unit dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
`ifdef ADDSUB_OP_EN
        .op_sub       (op_sub),
`endif
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Hands over A then B; returns #1 after the edge that accepted B.
    task automatic send_ab(input logic [31:0] a, input logic [31:0] b, input logic sub, output logic to);
        int n;
        to = 1'b0;
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (input_a_ack !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (input_a_ack !== 1'b1) to = 1'b1;
        @(posedge clk); #1;
        input_a_stb = 1'b0;
        input_b = b;
        op_sub = sub;
        input_b_stb = 1'b1;
        n = 0;
        while (input_b_ack !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (input_b_ack !== 1'b1) to = 1'b1;
        @(posedge clk); #1;
        input_b_stb = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] z, output int cyc, output logic to);
        logic to_ab;
        send_ab(a, b, sub, to_ab);
        output_z_ack = 1'b0;
        cyc = 0;
        while (output_z_stb !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        to = to_ab | (output_z_stb !== 1'b1);
        z = output_z;
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        input_a = 32'd0; input_b = 32'd0; op_sub = 1'b0;
        input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (input_a_ack !== 1'b0) begin failures++; $display("FAIL reset_a_ack got=%b exp=0", input_a_ack); end
        checks++; if (input_b_ack !== 1'b0) begin failures++; $display("FAIL reset_b_ack got=%b exp=0", input_b_ack); end
        checks++; if (output_z_stb !== 1'b0) begin failures++; $display("FAIL reset_z_stb got=%b exp=0", output_z_stb); end
        checks++; if (output_z !== 32'h0) begin failures++; $display("FAIL reset_z got=%h exp=00000000", output_z); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (input_a_ack !== 1'b1) begin failures++; $display("FAIL reset_release_a_ack got=%b exp=1", input_a_ack); end
    endtask

    task automatic test_basic_backpressure;
        logic to;
        int n;
        send_ab(32'h3F800000, 32'h40000000, 1'b0, to);
        output_z_ack = 1'b0;
        n = 0;
        while (output_z_stb !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (to || output_z_stb !== 1'b1) begin failures++; $display("FAIL basic_timeout got_stb=%b exp=1", output_z_stb); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (output_z_stb !== 1'b1 || output_z !== 32'h40400000) begin
                failures++; $display("FAIL basic_hold cycle=%0d got stb=%b z=%h exp stb=1 z=40400000", i, output_z_stb, output_z);
            end
            @(posedge clk); #1;
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
        checks++; if (output_z_stb !== 1'b0) begin failures++; $display("FAIL basic_one_transfer got_stb=%b exp=0", output_z_stb); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
            failures++; $display("FAIL basic_idle got stb=%b a_ack=%b exp stb=0 a_ack=1", output_z_stb, input_a_ack);
        end
    endtask

    // Latency 0 in the table means "normal path, bounded by 64 cycles".
    task automatic test_cancel_specials;
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [31:0] tz [5];
        int          tl [5];
        logic [31:0] z;
        int          cyc;
        logic        to;
        ta = '{32'h3FC00000, 32'h7F800000, 32'h80000000, 32'h7FC00001, 32'h3F800001};
        tb = '{32'hBFC00000, 32'hFF800000, 32'h80000000, 32'h3F800000, 32'hBF800000};
        tz = '{32'h00000000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'h34000000};
        tl = '{0, 3, 3, 3, 0};
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 1'b0, z, cyc, to);
            checks++;
            if (to || z !== tz[i]) begin
                failures++; $display("FAIL special_%0d got=%h exp=%h timeout=%b", i, z, tz[i], to);
            end
            checks++;
            if ((tl[i] != 0) ? (cyc != tl[i]) : (cyc > 64)) begin
                failures++; $display("FAIL special_latency_%0d got=%0d exp=%0d", i, cyc, tl[i]);
            end
        end
    endtask

    task automatic test_rounding_overflow;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] tz [4];
        logic [31:0] z;
        int          cyc;
        logic        to;
        ta = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00000001};
        tb = '{32'h33800000, 32'h33800001, 32'h7F7FFFFF, 32'h00000001};
        tz = '{32'h3F800000, 32'h3F800001, 32'h7F800000, 32'h00000002};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 1'b0, z, cyc, to);
            checks++;
            if (to || z !== tz[i] || cyc > 64) begin
                failures++; $display("FAIL round_ovf_%0d got=%h exp=%h cycles=%0d timeout=%b", i, z, tz[i], cyc, to);
            end
        end
    endtask

    task automatic test_subtract;
        logic [31:0] z;
        int          cyc;
        logic        to;
`ifdef ADDSUB_OP_EN
        run_op(32'h40400000, 32'h3F800000, 1'b1, z, cyc, to);
        checks++; if (to || z !== 32'h40000000) begin failures++; $display("FAIL sub_op got=%h exp=40000000", z); end
        run_op(32'h40400000, 32'h3F800000, 1'b0, z, cyc, to);
        checks++; if (to || z !== 32'h40800000) begin failures++; $display("FAIL sub_op_add got=%h exp=40800000", z); end
`else
        run_op(32'h40400000, 32'hBF800000, 1'b0, z, cyc, to);
        checks++; if (to || z !== 32'h40000000) begin failures++; $display("FAIL sub_flip got=%h exp=40000000", z); end
`endif
    endtask

    task automatic test_both_stb;
        logic        a_seen = 1'b0;
        logic        b_seen = 1'b0;
        logic        overlap = 1'b0;
        logic        order_bad = 1'b0;
        int          n;
        input_a = 32'h3F800000; input_b = 32'h3F800000; op_sub = 1'b0;
        output_z_ack = 1'b0;
        input_a_stb = 1'b1; input_b_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (input_a_ack === 1'b1 && input_b_ack === 1'b1) overlap = 1'b1;
            if (input_b_ack === 1'b1 && !a_seen) order_bad = 1'b1;
            if (input_a_ack === 1'b1) a_seen = 1'b1;
            if (input_b_ack === 1'b1) b_seen = 1'b1;
            @(posedge clk); #1;
        end
        input_a_stb = 1'b0; input_b_stb = 1'b0;
        checks++; if (overlap) begin failures++; $display("FAIL both_stb_overlap got=1 exp=0"); end
        checks++; if (!a_seen || !b_seen || order_bad) begin
            failures++; $display("FAIL both_stb_seq got a=%b b=%b order_bad=%b exp a=1 b=1 order_bad=0", a_seen, b_seen, order_bad);
        end
        n = 0;
        while (output_z_stb !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        checks++; if (output_z_stb !== 1'b1 || output_z !== 32'h40000000) begin
            failures++; $display("FAIL both_stb_result got stb=%b z=%h exp stb=1 z=40000000", output_z_stb, output_z);
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic        to;
        logic        stray = 1'b0;
        logic [31:0] z;
        int          cyc;
        send_ab(32'h3F800001, 32'hBF800000, 1'b0, to);
        output_z_ack = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (output_z_stb !== 1'b0 || output_z !== 32'h0 || input_a_ack !== 1'b0) begin
            failures++; $display("FAIL midrst_state got stb=%b z=%h a_ack=%b exp 0 00000000 0", output_z_stb, output_z, input_a_ack);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (input_a_ack !== 1'b1) begin failures++; $display("FAIL midrst_a_ack got=%b exp=1", input_a_ack); end
        for (int i = 0; i < 40; i++) begin
            if (output_z_stb !== 1'b0) stray = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (stray) begin failures++; $display("FAIL midrst_no_result got=1 exp=0"); end
        run_op(32'h3F800000, 32'h40000000, 1'b0, z, cyc, to);
        checks++; if (to || z !== 32'h40400000) begin failures++; $display("FAIL midrst_next_op got=%h exp=40400000", z); end
    endtask

    initial begin
        test_reset;
        test_basic_backpressure;
        test_cancel_specials;
        test_rounding_overflow;
        test_subtract;
        test_both_stb;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp32_add_sub_unit.md
Name: fp32_add_sub_unit

Overview:
- IEEE-754 single-precision floating-point adder/subtractor.
- Uses stb/ack valid-ready handshakes on two operand inputs and one result output.
- Serves as the shared add/subtract primitive for the iterative math datapaths (e.g. the bisection cube-root engine error and midpoint computations).
- Multi-cycle, one operation in flight at a time.

Parameters:
- None.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- input_a  input  32  operand A, IEEE-754 binary32
- input_a_stb  input  1  A valid
- input_a_ack  output  1  A ready; A accepted on cycle where stb&ack
- input_b  input  32  operand B, IEEE-754 binary32
- input_b_stb  input  1  B valid
- input_b_ack  output  1  B ready; B accepted on cycle where stb&ack
- op_sub  input  1  present only with ADDSUB_OP_EN; 1 = A-B, 0 = A+B; sampled when B is accepted
- output_z  output  32  result, binary32
- output_z_stb  output  1  result valid
- output_z_ack  input  1  consumer ready; result consumed on stb&ack

Behaviour:
- Reset (async, active-high):
  - FSM goes to GET_A.
  - input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
  - input_a_ack rises on first clock after reset release.
- Reset asserted mid-operation aborts the operation; no result is produced; partial operands are discarded.
- FSM: GET_A -> GET_B -> UNPACK -> SPECIAL -> ALIGN -> ADD -> NORMALISE -> ROUND -> PACK -> PUT_Z -> GET_A.
- GET_A:
  - input_a_ack=1.
  - On input_a_stb&input_a_ack: latch A, drop ack next cycle, go to GET_B.
- GET_B: same handshake for B (and op_sub).
  - A and B are never accepted in the same cycle, even if both stb are high.
- UNPACK: split sign, 8-bit exponent, 23-bit mantissa; unbias exponent by 127.
  - Subtraction is implemented by inverting B's sign.
- SPECIAL, results, in priority order:
  - Either NaN: 0x7FC00000.
  - inf + (-inf): 0x7FC00000.
  - Either inf: that inf with its sign.
  - Both zero: +0, except -0 + -0 = -0.
  - One zero: the other operand unchanged.
  - All special cases go directly to PUT_Z.
- Denormals:
  - Input exponent field 0 means unbiased exponent -126 with no hidden bit.
  - Subnormal results are produced, not flushed.
- Working mantissa is 27 bits: hidden + 23 + guard, round, sticky.
- ALIGN: shift the smaller-exponent operand right 1 bit per cycle until exponents match.
  - Shifted-out bits OR into sticky.
  - Alignment stops once the shift distance exceeds 26; the operand is then pure sticky.
- ADD:
  - Equal signs: add magnitudes.
  - Otherwise subtract smaller magnitude from larger; result takes the larger operand's sign.
  - Exact cancellation gives +0.
- NORMALISE:
  - On carry-out, shift right 1 and increment exponent.
  - Otherwise shift left 1 per cycle until hidden bit set, or until exponent reaches -126 (subnormal).
- ROUND: round-to-nearest-even using guard/round/sticky.
  - Mantissa overflow after rounding increments the exponent.
- PACK:
  - Exponent > 127 gives ±inf (0x7F800000 | sign).
  - Exponent -126 with hidden bit clear gives exponent field 0.
- PUT_Z:
  - output_z_stb=1, output_z stable until output_z_stb&output_z_ack.
  - Then stb=0 and return to GET_A.
  - Backpressure of any length is allowed.
- Latency, B acceptance to output_z_stb rising:
  - Special cases: 3 cycles.
  - Normal cases: data-dependent, at most 64 cycles.

Optional Feature:
- Macro ADDSUB_OP_EN.
- Defined: op_sub port exists; op_sub=1 computes A-B by inverting B's sign.
- Undefined: op_sub port absent, unit computes A+B only.
  - Subtraction is done by the caller flipping bit 31 of B.

Test Plan:
- Basic add, backpressure: 0x3F800000 + 0x40000000, output_z_ack held low 5 cycles -> output_z=0x40400000, stb held and z stable all 5 cycles, one transfer.
- Cancellation and specials:
  - 0x3FC00000 + 0xBFC00000 -> 0x00000000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
  - 0x3F800000 + 0x33800001 -> 0x3F800001.
- Overflow/subnormal:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x00000001 + 0x00000001 -> 0x00000002.
- Subtract (ADDSUB_OP_EN): A=0x40400000, B=0x3F800000, op_sub=1 -> 0x40000000.
- Handshake/reset:
  - Both stb high together -> a_ack and b_ack assert in different cycles.
  - rst pulsed during NORMALISE -> stb stays 0, a_ack=1 after release, next operation correct.
